// File: rtl/adxl345_pkg.sv
// rtl/adxl345_pkg.sv - shared types and constants for the ADXL345 shadow register bank
package adxl345_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } upd_state_t;

  // Bit i set means device byte i may be written from the CPU side
  localparam logic [63:0] ADXL_WRITE_MASK = 64'h0102_F7FF_E000_0000;

  localparam logic [7:0] REG_DEVID       = 8'h00;
  localparam logic [7:0] REG_BW_RATE     = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_DATAX0      = 8'h32;
  localparam logic [7:0] REG_FIFO_CTL    = 8'h38;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/adxl345_upd_scanner.sv
// rtl/adxl345_upd_scanner.sv - dirty-byte tracker and one-byte-per-command update engine
module adxl345_upd_scanner
  import adxl345_pkg::*;
#(
  parameter int N_BYTES    = 64,
  parameter int PTR_W      = 6,
  parameter int DEV_ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_BYTES-1:0]    i_set,
  input  logic [7:0]            i_byte,
  output logic [PTR_W-1:0]      o_ptr,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [DEV_ADDR_W-1:0] o_cmd_addr,
  output logic [7:0]            o_cmd_data,
  output logic                  o_busy
);

  upd_state_t            r_state, w_state_nxt;
  logic [N_BYTES-1:0]    r_dirty, w_clr;
  logic [PTR_W-1:0]      r_ptr, w_ptr_nxt, w_ptr_inc;
  logic                  r_cmd_valid, r_rearm, w_load, w_any_dirty;
  logic [DEV_ADDR_W-1:0] r_cmd_addr;
  logic [7:0]            r_cmd_data;

  assign w_any_dirty = |r_dirty;
  assign w_ptr_inc   = (r_ptr == PTR_W'(N_BYTES - 1)) ? '0 : r_ptr + PTR_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_clr       = '0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_any_dirty) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (!w_any_dirty) begin
          w_state_nxt = ST_IDLE;
        end else if (r_dirty[r_ptr]) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_ptr_nxt = w_ptr_inc;
        end
      end
      ST_ISSUE: begin
        if (i_cmd_ready) begin
          // A rewrite seen since capture must survive the handshake
          if (!r_rearm) w_clr = N_BYTES'(1) << r_ptr;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = ST_SCAN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_dirty     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_rearm     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dirty <= (r_dirty & ~w_clr) | i_set;
      if (w_load) begin
        r_cmd_valid <= 1'b1;
        r_cmd_addr  <= DEV_ADDR_W'(r_ptr);
        r_cmd_data  <= i_byte;
        r_rearm     <= i_set[r_ptr];
      end else if (r_state == ST_ISSUE) begin
        if (i_cmd_ready) r_cmd_valid <= 1'b0;
        if (i_set[r_ptr]) r_rearm <= 1'b1;
      end
    end
  end

  assign o_ptr       = r_ptr;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_addr  = r_cmd_addr;
  assign o_cmd_data  = r_cmd_data;
  assign o_busy      = w_any_dirty | r_cmd_valid;

endmodule

// File: rtl/axi_adxl345_regbank.sv
// rtl/axi_adxl345_regbank.sv - AXI4-Lite shadow register bank for the ADXL345 with read-back merge
module axi_adxl345_regbank
  import adxl345_pkg::*;
#(
  parameter int C_S_AXI_LITE_DATA_WIDTH = 32,
  parameter int C_S_AXI_LITE_ADDR_WIDTH = 8,
  parameter int N_REGS = 16,
  parameter logic [N_REGS*4-1:0] WRITE_MASK = (N_REGS*4)'(ADXL_WRITE_MASK),
  parameter int DEV_ADDR_W = 8
) (
  input  logic                                   S_AXI_LITE_ACLK,
  input  logic                                   S_AXI_LITE_ARESET,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]     S_AXI_LITE_AWADDR,
  input  logic [2:0]                             S_AXI_LITE_AWPROT,
  input  logic                                   S_AXI_LITE_AWVALID,
  output logic                                   S_AXI_LITE_AWREADY,
  input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]     S_AXI_LITE_WDATA,
  input  logic [C_S_AXI_LITE_DATA_WIDTH/8-1:0]   S_AXI_LITE_WSTRB,
  input  logic                                   S_AXI_LITE_WVALID,
  output logic                                   S_AXI_LITE_WREADY,
  output logic [1:0]                             S_AXI_LITE_BRESP,
  output logic                                   S_AXI_LITE_BVALID,
  input  logic                                   S_AXI_LITE_BREADY,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]     S_AXI_LITE_ARADDR,
  input  logic [2:0]                             S_AXI_LITE_ARPROT,
  input  logic                                   S_AXI_LITE_ARVALID,
  output logic                                   S_AXI_LITE_ARREADY,
  output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]     S_AXI_LITE_RDATA,
  output logic [1:0]                             S_AXI_LITE_RRESP,
  output logic                                   S_AXI_LITE_RVALID,
  input  logic                                   S_AXI_LITE_RREADY,
  output logic                                   CMD_VALID,
  input  logic                                   CMD_READY,
  output logic [DEV_ADDR_W-1:0]                  CMD_ADDR,
  output logic [7:0]                             CMD_DATA,
  input  logic                                   RB_VALID,
  input  logic [DEV_ADDR_W-1:0]                  RB_ADDR,
  input  logic [7:0]                             RB_DATA,
  output logic                                   BUSY
);

  localparam int N_BYTES = N_REGS * 4;
  localparam int WORD_W  = C_S_AXI_LITE_ADDR_WIDTH - 2;
  localparam int PTR_W   = $clog2(N_BYTES);

  if (C_S_AXI_LITE_DATA_WIDTH != 32 || (1 << C_S_AXI_LITE_ADDR_WIDTH) < N_BYTES) begin : g_param_check
    $error("axi_adxl345_regbank: unsupported data width or address width too small");
  end

  logic [7:0]         r_shadow [N_BYTES];
  logic               r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]         r_bresp, r_rresp;
  logic [31:0]        r_rdata, w_rd_word;
  logic [WORD_W-1:0]  w_aw_word, w_ar_word;
  logic               w_aw_ok, w_ar_ok, w_wr_en, w_rd_en;
  logic [N_BYTES-1:0] w_set;
  logic [PTR_W-1:0]   w_ptr;
  logic               w_unused;

  assign w_aw_word = S_AXI_LITE_AWADDR[C_S_AXI_LITE_ADDR_WIDTH-1:2];
  assign w_ar_word = S_AXI_LITE_ARADDR[C_S_AXI_LITE_ADDR_WIDTH-1:2];
  assign w_aw_ok   = int'(w_aw_word) < N_REGS;
  assign w_ar_ok   = int'(w_ar_word) < N_REGS;
  assign w_wr_en   = r_awready & S_AXI_LITE_AWVALID & S_AXI_LITE_WVALID;
  assign w_rd_en   = r_arready & S_AXI_LITE_ARVALID;
  assign w_unused  = ^{S_AXI_LITE_AWPROT, S_AXI_LITE_ARPROT,
                       S_AXI_LITE_AWADDR[1:0], S_AXI_LITE_ARADDR[1:0]};

  always_comb begin
    w_set = '0;
    for (int i = 0; i < N_BYTES; i++)
      w_set[i] = w_wr_en & w_aw_ok & (w_aw_word == WORD_W'(i / 4)) &
                 S_AXI_LITE_WSTRB[i % 4] & WRITE_MASK[i];
  end

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < N_REGS; k++)
      if (w_ar_word == WORD_W'(k))
        w_rd_word = {r_shadow[4*k+3], r_shadow[4*k+2], r_shadow[4*k+1], r_shadow[4*k]};
  end

  // CPU writes only reach writable bytes and read-back only read-only ones, so they never collide
  always_ff @(posedge S_AXI_LITE_ACLK) begin
    for (int i = 0; i < N_BYTES; i++) begin
      if (S_AXI_LITE_ARESET)
        r_shadow[i] <= '0;
      else if (w_set[i])
        r_shadow[i] <= S_AXI_LITE_WDATA[8*(i%4) +: 8];
      else if (RB_VALID && !WRITE_MASK[i] && RB_ADDR == DEV_ADDR_W'(i))
        r_shadow[i] <= RB_DATA;
    end
  end

  always_ff @(posedge S_AXI_LITE_ACLK) begin
    if (S_AXI_LITE_ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_awready <= S_AXI_LITE_AWVALID & S_AXI_LITE_WVALID & ~r_bvalid & ~r_awready;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_LITE_BREADY) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= S_AXI_LITE_ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_ar_ok ? w_rd_word : 32'd0;
        r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_LITE_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  adxl345_upd_scanner #(
    .N_BYTES    (N_BYTES),
    .PTR_W      (PTR_W),
    .DEV_ADDR_W (DEV_ADDR_W)
  ) u_scanner (
    .i_clk       (S_AXI_LITE_ACLK),
    .i_rst       (S_AXI_LITE_ARESET),
    .i_set       (w_set),
    .i_byte      (r_shadow[w_ptr]),
    .o_ptr       (w_ptr),
    .o_cmd_valid (CMD_VALID),
    .i_cmd_ready (CMD_READY),
    .o_cmd_addr  (CMD_ADDR),
    .o_cmd_data  (CMD_DATA),
    .o_busy      (BUSY)
  );

  assign S_AXI_LITE_AWREADY = r_awready;
  assign S_AXI_LITE_WREADY  = r_awready;
  assign S_AXI_LITE_BVALID  = r_bvalid;
  assign S_AXI_LITE_BRESP   = r_bresp;
  assign S_AXI_LITE_ARREADY = r_arready;
  assign S_AXI_LITE_RVALID  = r_rvalid;
  assign S_AXI_LITE_RDATA   = r_rdata;
  assign S_AXI_LITE_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_adxl345_regbank.sv
// tb/tb_axi_adxl345_regbank.sv - self-checking bench: vector table, corner sequences, random vs byte-map model
`timescale 1ns/1ps
module tb_axi_adxl345_regbank;
  import adxl345_pkg::*;

  localparam int NB = 64;
  localparam logic [63:0] MASK = 64'h0102_F7FF_E000_0000;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic cmd_valid, cmd_ready, busy;
  logic [7:0] cmd_addr, cmd_data;
  logic rb_valid = 0;
  logic [7:0] rb_addr = '0, rb_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 0;

  logic [15:0] cmd_q[$];
  bit         cmd_seen [256];
  logic [7:0] last_cmd [256];

  axi_adxl345_regbank dut (
    .S_AXI_LITE_ACLK(clk), .S_AXI_LITE_ARESET(rst),
    .S_AXI_LITE_AWADDR(awaddr), .S_AXI_LITE_AWPROT(awprot), .S_AXI_LITE_AWVALID(awvalid),
    .S_AXI_LITE_AWREADY(awready), .S_AXI_LITE_WDATA(wdata), .S_AXI_LITE_WSTRB(wstrb),
    .S_AXI_LITE_WVALID(wvalid), .S_AXI_LITE_WREADY(wready), .S_AXI_LITE_BRESP(bresp),
    .S_AXI_LITE_BVALID(bvalid), .S_AXI_LITE_BREADY(bready), .S_AXI_LITE_ARADDR(araddr),
    .S_AXI_LITE_ARPROT(arprot), .S_AXI_LITE_ARVALID(arvalid), .S_AXI_LITE_ARREADY(arready),
    .S_AXI_LITE_RDATA(rdata), .S_AXI_LITE_RRESP(rresp), .S_AXI_LITE_RVALID(rvalid),
    .S_AXI_LITE_RREADY(rready), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .RB_VALID(rb_valid), .RB_ADDR(rb_addr),
    .RB_DATA(rb_data), .BUSY(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: cmd_ready = 1'b1;
        1: cmd_ready = 1'b0;
        default: cmd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      cmd_q.push_back({cmd_addr, cmd_data});
      cmd_seen[cmd_addr] = 1'b1;
      last_cmd[cmd_addr] = cmd_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; rb_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmd_q.delete();
    for (int i = 0; i < 256; i++) begin cmd_seen[i] = 1'b0; last_cmd[i] = '0; end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int c;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    c = 0;
    @(negedge clk);
    while (!awready && c < 20) begin @(negedge clk); c++; end
    check("aw_handshake", {31'd0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; bready = 1;
    c = 0;
    @(negedge clk);
    while (!bvalid && c < 20) begin @(negedge clk); c++; end
    check("b_valid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int c;
    araddr = a; arvalid = 1;
    c = 0;
    @(negedge clk);
    while (!arready && c < 20) begin @(negedge clk); c++; end
    check("ar_handshake", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 0; rready = 1;
    c = 0;
    @(negedge clk);
    while (!rvalid && c < 20) begin @(negedge clk); c++; end
    check("r_valid_seen", {31'd0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    @(negedge clk);
    while (busy && c < max_cyc) begin @(negedge clk); c++; end
    check("busy_drains", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_cmd(input int max_cyc);
    int c;
    c = 0;
    @(negedge clk);
    while (!cmd_valid && c < max_cyc) begin @(negedge clk); c++; end
    check("cmd_valid_seen", {31'd0, cmd_valid}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[9];
  logic [7:0] model [NB];
  bit         wrote [NB];

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [7:0]  a0, a1;
    bit          ok;
    int          strays;

    vecs[0] = '{8'h00, 32'hFFFF_FFFF, 4'hF, OK, OK, 32'h0000_0000};
    vecs[1] = '{8'h1C, 32'h1234_5678, 4'hF, OK, OK, 32'h1234_5600};
    vecs[2] = '{8'h28, 32'hAABB_CCDD, 4'hF, OK, OK, 32'h00BB_CCDD};
    vecs[3] = '{8'h30, 32'h1122_3344, 4'h3, OK, OK, 32'h0000_3300};
    vecs[4] = '{8'h38, 32'hFFFF_FFFF, 4'h1, OK, OK, 32'h0000_00FF};
    vecs[5] = '{8'h3C, 32'hFFFF_FFFF, 4'hF, OK, OK, 32'h0000_0000};
    vecs[6] = '{8'h50, 32'hDEAD_BEEF, 4'hF, SE, SE, 32'h0000_0000};
    vecs[7] = '{8'h40, 32'h0102_0304, 4'hF, SE, SE, 32'h0000_0000};
    vecs[8] = '{8'hFC, 32'h5555_5555, 4'hF, SE, SE, 32'h0000_0000};

    do_reset();
    @(negedge clk);
    check("rst_awready", {31'd0, awready}, 0);
    check("rst_bvalid", {31'd0, bvalid}, 0);
    check("rst_arready", {31'd0, arready}, 0);
    check("rst_rvalid", {31'd0, rvalid}, 0);
    check("rst_resp", {28'd0, bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cmd", {15'd0, cmd_valid, cmd_addr, cmd_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    tick();

    ready_mode = 0;
    for (int i = 0; i < 9; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
      check($sformatf("vec%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].bresp});
      axi_read(vecs[i].addr, d, r);
      check($sformatf("vec%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].rresp});
      check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
    end
    wait_idle(500);

    // Full word write to BW_RATE..0x2F drains in ascending byte order
    do_reset();
    axi_write(REG_BW_RATE, 32'h0080_080A, 4'hF, r);
    check("bw_bresp", {30'd0, r}, OK);
    @(negedge clk);
    check("bw_busy_high", {31'd0, busy}, 1);
    tick();
    wait_idle(500);
    check("bw_cmd_count", cmd_q.size(), 4);
    if (cmd_q.size() == 4) begin
      check("bw_cmd0", {16'd0, cmd_q[0]}, 32'h2C0A);
      check("bw_cmd1", {16'd0, cmd_q[1]}, 32'h2D08);
      check("bw_cmd2", {16'd0, cmd_q[2]}, 32'h2E80);
      check("bw_cmd3", {16'd0, cmd_q[3]}, 32'h2F00);
    end
    axi_read(REG_BW_RATE, d, r);
    check("bw_readback", d, 32'h0080_080A);

    // Fully masked word: no commands
    do_reset();
    axi_write(REG_DEVID, 32'hFFFF_FFFF, 4'hF, r);
    check("devid_bresp", {30'd0, r}, OK);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cmd_valid || busy) ok = 1'b0;
    end
    tick();
    check("devid_quiet", {31'd0, ok}, 1);
    axi_read(REG_DEVID, d, r);
    check("devid_read", d, 0);

    // Read-back merge: read-only byte lands, writable byte ignored
    do_reset();
    rb_valid = 1; rb_addr = REG_DATAX0; rb_data = 8'h5A; tick();
    rb_addr = REG_DATA_FORMAT; rb_data = 8'h77; tick();
    rb_valid = 0;
    axi_read(8'h30, d, r);
    check("rb_read", d, 32'h005A_0000);
    check("rb_rresp", {30'd0, r}, OK);
    repeat (4) tick();
    check("rb_no_cmd", cmd_q.size(), 0);

    // Stalled command with a rewrite during ISSUE
    do_reset();
    ready_mode = 1;
    axi_write(REG_FIFO_CTL, 32'h0000_0099, 4'hF, r);
    wait_cmd(200);
    a0 = cmd_addr; a1 = cmd_data;
    check("stall_addr", {24'd0, a0}, 32'h38);
    check("stall_data", {24'd0, a1}, 32'h99);
    tick();
    axi_write(REG_FIFO_CTL, 32'h0000_00A5, 4'h1, r);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!cmd_valid || cmd_addr !== a0 || cmd_data !== a1) ok = 1'b0;
    end
    check("stall_stable", {31'd0, ok}, 1);
    tick();
    ready_mode = 0;
    wait_idle(500);
    check("stall_cmd_count", cmd_q.size(), 2);
    if (cmd_q.size() == 2) begin
      check("stall_cmd0", {16'd0, cmd_q[0]}, 32'h3899);
      check("stall_cmd1", {16'd0, cmd_q[1]}, 32'h38A5);
    end

    // Out-of-range word
    do_reset();
    axi_write(8'h50, 32'h1234_5678, 4'hF, r);
    check("oor_bresp", {30'd0, r}, SE);
    axi_read(8'h50, d, r);
    check("oor_rresp", {30'd0, r}, SE);
    check("oor_rdata", d, 0);
    repeat (4) tick();
    check("oor_no_cmd", cmd_q.size() + {31'd0, busy}, 0);

    // Reset while a command is pending
    do_reset();
    ready_mode = 1;
    axi_write(REG_BW_RATE, 32'h0000_1100, 4'h2, r);
    wait_cmd(200);
    check("mid_addr", {24'd0, cmd_addr}, 32'h2D);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("mid_cmd_dropped", {30'd0, cmd_valid, busy}, 0);
    ready_mode = 0;
    repeat (4) tick();
    @(negedge clk);
    check("mid_no_resume", {30'd0, cmd_valid, busy}, 0);
    tick();
    axi_read(REG_BW_RATE, d, r);
    check("mid_shadow_clear", d, 0);

    // Random traffic against a byte-map model
    do_reset();
    for (int i = 0; i < NB; i++) begin model[i] = '0; wrote[i] = 1'b0; end
    ready_mode = 2;
    for (int it = 0; it < 60; it++) begin
      int op, w, b;
      logic [31:0] rd_val;
      logic [3:0]  s;
      op = $urandom_range(0, 9);
      if (op < 5) begin
        w = $urandom_range(0, 19);
        rd_val = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(8'(w * 4), rd_val, s, r);
        check("rnd_bresp", {30'd0, r}, (w < 16) ? OK : SE);
        if (w < 16)
          for (int j = 0; j < 4; j++) begin
            b = w * 4 + j;
            if (s[j] && MASK[b]) begin model[b] = rd_val[8*j +: 8]; wrote[b] = 1'b1; end
          end
      end else if (op < 8) begin
        b = $urandom_range(0, 71);
        rb_valid = 1; rb_addr = 8'(b); rb_data = 8'($urandom);
        if (b < NB && !MASK[b]) model[b] = rb_data;
        tick();
        rb_valid = 0;
      end else begin
        w = $urandom_range(0, 19);
        axi_read(8'(w * 4), d, r);
        check("rnd_rresp", {30'd0, r}, (w < 16) ? OK : SE);
        check("rnd_rdata", d, (w < 16) ? {model[w*4+3], model[w*4+2], model[w*4+1], model[w*4]} : 32'd0);
      end
    end
    ready_mode = 0;
    wait_idle(5000);
    strays = 0;
    for (int i = 0; i < NB; i++) begin
      if (wrote[i])
        check($sformatf("rnd_last_cmd_%02h", i), {23'd0, cmd_seen[i], last_cmd[i]}, {23'd0, 1'b1, model[i]});
      else if (cmd_seen[i])
        strays++;
    end
    check("rnd_stray_cmds", strays, 0);
    for (int w = 0; w < 16; w++) begin
      axi_read(8'(w * 4), d, r);
      check($sformatf("rnd_final_word%0d", w), d, {model[w*4+3], model[w*4+2], model[w*4+1], model[w*4]});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
